// File: rtl/nitta_to_i2c_serializer.sv
// nitta_to_i2c_serializer
//   Buffers NITTA words in a small FIFO and emits each one as a sequence of
//   I2C_DATA_WIDTH-bit subframes. A rising edge on i2c_ready consumes the
//   current subframe. Words narrower than a whole number of subframes are
//   zero-extended, so padding sits in the top of the most significant subframe.
// Ports:
//   clk, rst        single clock, synchronous active-high reset
//   nitta_valid     from_nitta holds a word to enqueue
//   from_nitta      word to enqueue
//   splitter_ready  FIFO not full
//   overflow        sticky: a write was attempted while full
//   pending         FIFO occupancy (excludes the word being shifted out)
//   i2c_ready       level from the I2C slave; low->high consumes a subframe
//   to_i2c          current subframe (registered)
//   to_i2c_valid    to_i2c holds a valid subframe
//   frame_last      current subframe is the last of its word
module nitta_to_i2c_serializer #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned I2C_DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned MSB_FIRST      = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 nitta_valid,
    input  logic [DATA_WIDTH-1:0]                from_nitta,
    output logic                                 splitter_ready,
    output logic                                 overflow,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      pending,
    input  logic                                 i2c_ready,
    output logic [I2C_DATA_WIDTH-1:0]            to_i2c,
    output logic                                 to_i2c_valid,
    output logic                                 frame_last
);

    localparam int unsigned SUB_N = (DATA_WIDTH + I2C_DATA_WIDTH - 1) / I2C_DATA_WIDTH;
    localparam int unsigned PAD_W = SUB_N * I2C_DATA_WIDTH;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned CW    = (SUB_N > 1) ? $clog2(SUB_N) : 1;

    localparam logic [CW-1:0]    LAST_IDX = CW'(SUB_N - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [DATA_WIDTH-1:0]     fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic                      overflow_q, overflow_d;
    logic [0:0]                state_q, state_d;
    logic [CW-1:0]             counter_q, counter_d;
    logic [PAD_W-1:0]          shift_q, shift_d;
    logic                      i2c_prev_q;
    logic [I2C_DATA_WIDTH-1:0] to_i2c_q, to_i2c_d;
    logic                      valid_q, valid_d;
    logic                      last_q, last_d;

    logic full, wr_en, pop, consume, at_last;

    // Subframe select: counter 0 is the first subframe sent in the chosen order.
    function automatic logic [I2C_DATA_WIDTH-1:0] pick(input logic [PAD_W-1:0] s,
                                                       input logic [CW-1:0]    c);
        int unsigned idx;
        idx = (MSB_FIRST != 0) ? (SUB_N - 1 - 32'(c)) : 32'(c);
        return s[idx*I2C_DATA_WIDTH +: I2C_DATA_WIDTH];
    endfunction

    always_comb begin
        full       = (count_q == FULL_CNT);
        wr_en      = nitta_valid && !full;
        overflow_d = overflow_q || (nitta_valid && full);
        consume    = i2c_ready && !i2c_prev_q && (state_q == SEND);
        at_last    = (counter_q == LAST_IDX);

        pop       = 1'b0;
        state_d   = state_q;
        counter_d = counter_q;
        shift_d   = shift_q;

        if (state_q == IDLE) begin
            if (count_q != '0) pop = 1'b1;
        end else if (consume) begin
            if (!at_last)              counter_d = counter_q + 1'b1;
            else if (count_q != '0)    pop = 1'b1;
            else                       state_d = IDLE;
        end

        if (pop) begin
            shift_d   = PAD_W'(fifo_mem_q[rd_ptr_q]);
            counter_d = '0;
            state_d   = SEND;
        end

        wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop   ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (wr_en && !pop)      count_d = count_q + 1'b1;
        else if (!wr_en && pop) count_d = count_q - 1'b1;

        // Outputs are registered from next-state so they are valid the cycle after the edge.
        valid_d  = (state_d == SEND);
        to_i2c_d = valid_d ? pick(shift_d, counter_d) : '0;
        last_d   = valid_d && (counter_d == LAST_IDX);
    end

    always_ff @(posedge clk) begin
        i2c_prev_q <= i2c_ready;
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            state_q    <= IDLE;
            counter_q  <= '0;
            shift_q    <= '0;
            to_i2c_q   <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            counter_q  <= counter_d;
            shift_q    <= shift_d;
            to_i2c_q   <= to_i2c_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) fifo_mem_q[wr_ptr_q] <= from_nitta;
    end

    assign splitter_ready = !full;
    assign overflow       = overflow_q;
    assign pending        = count_q;
    assign to_i2c         = to_i2c_q;
    assign to_i2c_valid   = valid_q;
    assign frame_last     = last_q;

endmodule

// File: doc/nitta_to_i2c_serializer.md
# nitta_to_i2c_serializer

Buffered, parametrised word-to-subframe serializer between the NITTA processor data bus and the I2C slave byte interface. It accepts full NITTA words through a valid/ready handshake into a small FIFO. Each word is emitted as a sequence of I2C_DATA_WIDTH subframes, and the I2C side advances the sequence on each rising edge of its ready level. It supersedes the single-word splitter with three additions: queueing, a selectable byte order, and support for data widths that are not a multiple of the subframe width.

## Interface
- DATA_WIDTH, 32: NITTA word width.
- I2C_DATA_WIDTH, 8: subframe width.
- FIFO_DEPTH, 4: words buffered. Must be a power of two and ≥ 2.
- MSB_FIRST, 1: 1 sends the most significant subframe first; 0 sends the least significant first.
- clk  input  1  clock. Single clock domain.
- rst  input  1  reset. Synchronous, active-high.
- nitta_valid  input  1  from_nitta holds a word to enqueue.
- from_nitta  input  DATA_WIDTH  word to enqueue.
- splitter_ready  output  1  FIFO not full; a word can be accepted.
- overflow  output  1  sticky flag: a write was attempted while the FIFO was full.
- pending  output  $clog2(FIFO_DEPTH+1)  FIFO occupancy. Excludes the word currently being shifted out.
- i2c_ready  input  1  level from the I2C slave. A low→high transition consumes the current subframe.
- to_i2c  output  I2C_DATA_WIDTH  current subframe, registered.
- to_i2c_valid  output  1  to_i2c holds a valid subframe.
- frame_last  output  1  the current subframe is the last one of its word.

## Operation
- SUBFRAME_NUMBER = ceil(DATA_WIDTH / I2C_DATA_WIDTH).
  - The word is zero-extended to SUBFRAME_NUMBER*I2C_DATA_WIDTH bits before splitting.
  - Padding therefore always lands in the upper bits of the most significant subframe.
- Enqueue: happens on any edge where nitta_valid && splitter_ready.
  - nitta_valid while full: the word is dropped, FIFO unchanged, overflow set to 1 until rst.
- Edge detect:
  - i2c_prev <= i2c_ready on every edge, including during rst.
  - consume = i2c_ready && !i2c_prev && state==SEND.
  - An i2c_ready held high through reset release is therefore not a consume.
- State machine:
  - IDLE: to_i2c_valid=0, to_i2c=0, frame_last=0. If pending>0, pop the FIFO head into the shift register, set counter=0, go to SEND.
  - SEND: to_i2c_valid=1. to_i2c = subframe[counter] in the configured order. frame_last = (counter == SUBFRAME_NUMBER-1).
  - On consume with counter < SUBFRAME_NUMBER-1: counter+1.
  - On consume with counter == SUBFRAME_NUMBER-1:
    - pending>0: pop the next word, counter=0, stay in SEND (back-to-back words, no bubble).
    - pending==0: go to IDLE.
- Simultaneous enqueue and pop on the same edge:
  - Both take effect; pending is unchanged.
  - splitter_ready is evaluated from pre-edge occupancy, so a write when full is rejected even if a pop happens on the same edge.
- SUBFRAME_NUMBER==1: every subframe has frame_last=1, and each consume pops a word.

## Timing
- Reset values:
  - splitter_ready=1, overflow=0, pending=0, to_i2c=0, to_i2c_valid=0, frame_last=0, state=IDLE, FIFO pointers=0.
  - i2c_prev = i2c_ready, sampled during rst.
- Reset mid-word: the in-flight word and all FIFO contents are discarded. The cycle after rst deasserts shows reset values.
- Enqueue latency with empty FIFO and state IDLE: write accepted at edge N → pending=1 after N → popped at edge N+1 → to_i2c_valid=1 with the first subframe after N+1.
- Consume latency: i2c_ready rises between edges E-1 and E → consume at edge E → next subframe, or IDLE, visible after E.
- The minimum subframe period is 2 cycles: i2c_ready must go low and back high.
- splitter_ready and pending are registered-state derived. They update the cycle after an enqueue or pop edge.

## Test plan
- Reset then single word, DATA_WIDTH=32, MSB_FIRST=1: write 0xA1B2C3D4, then pulse i2c_ready 4 times.
  - Required: to_i2c = 0xA1, 0xB2, 0xC3, 0xD4; frame_last=1 only on 0xD4; then to_i2c_valid=0, to_i2c=0.
- MSB_FIRST=0 with the same word.
  - Required: to_i2c = 0xD4, 0xC3, 0xB2, 0xA1.
- DATA_WIDTH=20, I2C_DATA_WIDTH=8: write 0xABCDE.
  - Required: 3 subframes 0x0A, 0xBC, 0xDE (MSB_FIRST=1).
- FIFO full/overflow, FIFO_DEPTH=4, i2c_ready held low:
  - Write 5 words; the first is popped immediately, so 4 more fill the FIFO: pending=4, splitter_ready=0.
  - A 6th write sets overflow=1 and is dropped.
  - Drain all words in order. The next word's first subframe appears on the consume edge of the previous word's last subframe.
- i2c_ready held high across reset release, then a word written.
  - Required: no consume until i2c_ready goes low then high. The first subframe stays on to_i2c meanwhile.
- Reset asserted after 2 of 4 subframes, with 2 words pending.
  - Required: all outputs return to reset values next cycle, and the old data never reappears.
